// File: rtl/trig_clk_ps_sequencer_if.sv
// Register-side and MMCM-side signal bundle for trig_clk_ps_sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface trig_clk_ps_sequencer_if #(
    parameter int pSTEP_WIDTH = 12,
    parameter int pPOS_WIDTH  = 16
);
    logic                   I_start;
    logic [pSTEP_WIDTH-1:0] I_steps;
    logic                   I_incdec;
    logic                   I_abort;
    logic                   I_clear_position;
    logic                   I_psdone;
    logic                   O_psen;
    logic                   O_psincdec;
    logic                   O_busy;
    logic                   O_done;
    logic                   O_timeout;
    logic [pSTEP_WIDTH-1:0] O_remaining;
    logic [pPOS_WIDTH-1:0]  O_position;

    modport slave (
        input  I_start, I_steps, I_incdec, I_abort, I_clear_position, I_psdone,
        output O_psen, O_psincdec, O_busy, O_done, O_timeout, O_remaining, O_position
    );

    modport master (
        output I_start, I_steps, I_incdec, I_abort, I_clear_position, I_psdone,
        input  O_psen, O_psincdec, O_busy, O_done, O_timeout, O_remaining, O_position
    );
endinterface

// File: rtl/trig_clk_ps_sequencer.sv
// Multi-step MMCM dynamic phase-shift sequencer: N requested steps become N psen pulses paced by psdone.
// Optional WAIT-state watchdog enabled by defining PS_TIMEOUT_EN.
module trig_clk_ps_sequencer #(
    parameter int pSTEP_WIDTH     = 12,
    parameter int pPOS_WIDTH      = 16,
    parameter int pSETTLE_CYCLES  = 2,
    parameter int pTIMEOUT_CYCLES = 1023
) (
    input  logic                     cwusb_clk,
    input  logic                     reset_i,
    trig_clk_ps_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT, ST_SETTLE} state_t;

    localparam int SW = (pSETTLE_CYCLES > 1) ? $clog2(pSETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = (pSETTLE_CYCLES > 0) ? SW'(pSETTLE_CYCLES - 1) : '0;

    state_t                 r_state;
    logic                   r_abort;
    logic [SW-1:0]          r_settle;
    logic                   r_psen;
    logic                   r_psincdec;
    logic                   r_busy;
    logic                   r_done;
    logic [pSTEP_WIDTH-1:0] r_remaining;
    logic [pPOS_WIDTH-1:0]  r_position;
    logic                   w_abort;
    logic [pPOS_WIDTH-1:0]  w_pos_next;

`ifdef PS_TIMEOUT_EN
    localparam int TW = (pTIMEOUT_CYCLES > 1) ? $clog2(pTIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(pTIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_timer;
    logic          r_timeout;
`endif

    // An abort raised in the same cycle as psdone/settle expiry is honoured immediately.
    assign w_abort    = r_abort | bus.I_abort;
    assign w_pos_next = r_psincdec ? r_position + 1'b1 : r_position - 1'b1;

    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_abort     <= 1'b0;
            r_settle    <= '0;
            r_psen      <= 1'b0;
            r_psincdec  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_position  <= '0;
`ifdef PS_TIMEOUT_EN
            r_timer     <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_psen <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.I_start) begin
`ifdef PS_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        if (bus.I_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= bus.I_steps;
                            r_psincdec  <= bus.I_incdec;
                            r_psen      <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_PULSE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (bus.I_abort) r_abort <= 1'b1;
`ifdef PS_TIMEOUT_EN
                    r_timer <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.I_abort) r_abort <= 1'b1;
                    if (bus.I_psdone) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_position  <= w_pos_next;
                        if (r_remaining == pSTEP_WIDTH'(1) || w_abort) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_abort <= 1'b0;
                        end else if (pSETTLE_CYCLES == 0) begin
                            r_psen  <= 1'b1;
                            r_state <= ST_PULSE;
                        end else begin
                            r_settle <= SETTLE_LOAD;
                            r_state  <= ST_SETTLE;
                        end
                    end
`ifdef PS_TIMEOUT_EN
                    else if (r_timer == TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_abort   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
`endif
                end
                ST_SETTLE: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_abort <= 1'b0;
                    end else if (r_settle == '0) begin
                        r_psen  <= 1'b1;
                        r_state <= ST_PULSE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Clearing wins over a same-cycle step update.
            if (bus.I_clear_position) r_position <= '0;
        end
    end

    assign bus.O_psen      = r_psen;
    assign bus.O_psincdec  = r_psincdec;
    assign bus.O_busy      = r_busy;
    assign bus.O_done      = r_done;
    assign bus.O_remaining = r_remaining;
    assign bus.O_position  = r_position;
`ifdef PS_TIMEOUT_EN
    assign bus.O_timeout   = r_timeout;
`else
    // No watchdog in this build; the flag is a constant 0.
    assign bus.O_timeout   = (pTIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_trig_clk_ps_sequencer.sv
// Directed bench for trig_clk_ps_sequencer with a per-request scoreboard of final position/remaining/pulse count.
module tb_trig_clk_ps_sequencer;
    localparam int STEP_W = 12;
    localparam int POS_W  = 16;
    localparam int SETTLE = 2;
    localparam int TMO    = 20;
    localparam int DLY    = 3;

    typedef struct {
        logic [POS_W-1:0]  pos;
        logic [STEP_W-1:0] rem;
        int                npsen;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_psen   = 0;
    int   n_done   = 0;
    logic [POS_W-1:0]  exp_pos = '0;
    logic [STEP_W-1:0] exp_rem = '0;
    sb_t  sb[$];

    trig_clk_ps_sequencer_if #(.pSTEP_WIDTH(STEP_W), .pPOS_WIDTH(POS_W)) bus ();

    trig_clk_ps_sequencer #(
        .pSTEP_WIDTH(STEP_W), .pPOS_WIDTH(POS_W),
        .pSETTLE_CYCLES(SETTLE), .pTIMEOUT_CYCLES(TMO)
    ) dut (
        .cwusb_clk(clk),
        .reset_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.O_psen) n_psen++;
        if (bus.O_done) n_done++;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_psen(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.O_psen === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic request(input int steps, input bit inc, input int abort_step,
                           input bit clr_last, input bit poke_start);
        int  n;
        int  last_p;
        int  psen0;
        int  done0;
        bit  ok;
        sb_t e;
        n = (abort_step != 0) ? abort_step : steps;
        if (clr_last) exp_pos = '0;
        else if (inc) exp_pos = exp_pos + POS_W'(n);
        else exp_pos = exp_pos - POS_W'(n);
        if (steps != 0) exp_rem = STEP_W'(steps - n);
        e.pos = exp_pos; e.rem = exp_rem; e.npsen = n;
        sb.push_back(e);
        psen0 = n_psen; done0 = n_done; last_p = 0;

        bus.I_steps = STEP_W'(steps); bus.I_incdec = inc; bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        check("busy_after_start", bus.O_busy, (steps != 0));
        if (n == 0) begin
            check("zero_done", bus.O_done, 1);
            check("zero_psen", bus.O_psen, 0);
        end
        for (int s = 1; s <= n; s++) begin
            wait_psen(ok);
            check("psen_seen", ok, 1);
            if (!ok) return;
            if (s > 1) check("psen_spacing", cyc - last_p, DLY + 1 + SETTLE);
            last_p = cyc;
            check("psincdec", bus.O_psincdec, inc);
            tick();
            if (s == abort_step) bus.I_abort = 1'b1;
            if (poke_start && s == 1) begin
                bus.I_start = 1'b1; bus.I_steps = 12'd7; bus.I_incdec = ~inc;
            end
            tick();
            bus.I_abort = 1'b0; bus.I_start = 1'b0;
            tick();
            bus.I_psdone = 1'b1;
            if (clr_last && s == n) bus.I_clear_position = 1'b1;
            tick();
            bus.I_psdone = 1'b0; bus.I_clear_position = 1'b0;
            check("remaining_step", bus.O_remaining, steps - s);
            check("done_timing", bus.O_done, (s == n));
            check("busy_step", bus.O_busy, (s != n));
        end
        e = sb.pop_front();
        check("sb_position", bus.O_position, e.pos);
        check("sb_remaining", bus.O_remaining, e.rem);
        check("sb_psen_count", n_psen - psen0, e.npsen);
        tick();
        check("done_count", n_done - done0, 1);
        check("done_width", bus.O_done, 0);
    endtask

    initial begin
        int  psen0;
        int  done0;
        bit  ok;
        bus.I_start = 1'b0; bus.I_steps = '0; bus.I_incdec = 1'b0; bus.I_abort = 1'b0;
        bus.I_clear_position = 1'b0; bus.I_psdone = 1'b0;
        tick(); tick();
        check("rst_psen", bus.O_psen, 0);
        check("rst_busy", bus.O_busy, 0);
        check("rst_done", bus.O_done, 0);
        check("rst_timeout", bus.O_timeout, 0);
        check("rst_remaining", bus.O_remaining, 0);
        check("rst_position", bus.O_position, 0);
        check("rst_psincdec", bus.O_psincdec, 0);
        rst = 1'b0;
        tick();

        request(5, 1'b1, 0, 1'b0, 1'b0);   // position 5
        request(0, 1'b1, 0, 1'b0, 1'b0);   // zero-step
        request(10, 1'b0, 3, 1'b0, 1'b0);  // abort in third WAIT: position 2, remaining 7

        psen0 = n_psen;
        bus.I_psdone = 1'b1; tick(); bus.I_psdone = 1'b0; tick();
        check("stray_position", bus.O_position, exp_pos);
        check("stray_remaining", bus.O_remaining, exp_rem);
        check("stray_busy", bus.O_busy, 0);
        check("stray_psen", n_psen - psen0, 0);

        request(4, 1'b0, 0, 1'b0, 1'b1);   // wraps through zero; start-while-busy ignored
        request(2, 1'b1, 0, 1'b1, 1'b0);   // clear with final psdone

`ifdef PS_TIMEOUT_EN
        psen0 = n_psen;
        bus.I_steps = 12'd2; bus.I_incdec = 1'b1; bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        wait_psen(ok);
        check("tmo_psen_seen", ok, 1);
        for (int i = 0; i < TMO; i++) tick();
        check("tmo_not_yet", bus.O_timeout, 0);
        check("tmo_done_not_yet", bus.O_done, 0);
        tick();
        check("tmo_flag", bus.O_timeout, 1);
        check("tmo_done", bus.O_done, 1);
        check("tmo_busy", bus.O_busy, 0);
        check("tmo_remaining", bus.O_remaining, 2);
        check("tmo_position", bus.O_position, exp_pos);
        check("tmo_psen_count", n_psen - psen0, 1);
        exp_rem = 12'd2;
        tick();
        check("tmo_sticky", bus.O_timeout, 1);
        bus.I_steps = '0; bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        check("tmo_cleared", bus.O_timeout, 0);
        check("tmo_clear_done", bus.O_done, 1);
        tick();
`else
        psen0 = n_psen;
        bus.I_steps = 12'd1; bus.I_incdec = 1'b1; bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        wait_psen(ok);
        check("nowd_psen_seen", ok, 1);
        for (int i = 0; i < 2 * TMO; i++) tick();
        check("nowd_busy", bus.O_busy, 1);
        check("nowd_timeout", bus.O_timeout, 0);
        check("nowd_done", bus.O_done, 0);
        check("nowd_psen_count", n_psen - psen0, 1);
        bus.I_psdone = 1'b1; tick(); bus.I_psdone = 1'b0;
        exp_pos = exp_pos + 1'b1; exp_rem = '0;
        check("nowd_final_done", bus.O_done, 1);
        check("nowd_position", bus.O_position, exp_pos);
        check("nowd_remaining", bus.O_remaining, 0);
        tick();
`endif

        done0 = n_done;
        bus.I_steps = 12'd3; bus.I_incdec = 1'b1; bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
        wait_psen(ok);
        check("rstw_psen_seen", ok, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy", bus.O_busy, 0);
        check("rstw_psen", bus.O_psen, 0);
        check("rstw_done", bus.O_done, 0);
        check("rstw_remaining", bus.O_remaining, 0);
        check("rstw_position", bus.O_position, 0);
        check("rstw_psincdec", bus.O_psincdec, 0);
        check("rstw_timeout", bus.O_timeout, 0);
        tick(); tick(); tick();
        check("rstw_no_done", n_done - done0, 0);
        exp_pos = '0; exp_rem = '0;
        request(1, 1'b1, 0, 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
